// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation controller: grants up to two RRF entries per cycle,
// tracks the dispatch pointer and free-entry count, and rolls back on misprediction.
module rob_alloc_ctrl #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req1,
  input  logic               req2,
  input  logic               stall_ext,
  input  logic [1:0]         comnum,
  input  logic               prmiss,
  input  logic [RRF_SEL-1:0] prmiss_ptr,
  output logic               dp1,
  output logic               dp2,
  output logic [RRF_SEL-1:0] dp1_addr,
  output logic [RRF_SEL-1:0] dp2_addr,
  output logic [RRF_SEL-1:0] dispatchptr,
  output logic [RRF_SEL:0]   rrf_freenum,
  output logic               allocatable,
  output logic               recovering
);

  localparam logic [0:0]         ST_RUN     = 1'b0;
  localparam logic [0:0]         ST_RECOVER = 1'b1;
  localparam logic [RRF_SEL:0]   FREE_MAX   = (RRF_SEL+1)'(RRF_NUM);
  localparam logic [RRF_SEL+1:0] FREE_MAX_W = (RRF_SEL+2)'(RRF_NUM);
  localparam logic [RRF_SEL-1:0] PTR_ONE    = (RRF_SEL)'(1);

  logic [0:0]         state;
  logic [1:0]         reqcnt;
  logic [1:0]         grantcnt;
  logic               go;
  logic [RRF_SEL-1:0] squash;
  logic [RRF_SEL+1:0] free_run;
  logic [RRF_SEL+1:0] free_miss;
  logic [RRF_SEL+1:0] used_cnt;

  // Grants are all-or-nothing against the registered free count; entries
  // committed this cycle only become allocatable next cycle.
  always_comb begin
    reqcnt      = {1'b0, req1} + {1'b0, req1 & req2};
    allocatable = (rrf_freenum >= {{(RRF_SEL-1){1'b0}}, reqcnt});
    go          = (state == ST_RUN) & ~prmiss & ~stall_ext & allocatable;
    dp1         = go & req1;
    dp2         = go & req1 & req2;
    grantcnt    = {1'b0, dp1} + {1'b0, dp2};
    squash      = dispatchptr - prmiss_ptr;
    free_run    = {1'b0, rrf_freenum} + {{RRF_SEL{1'b0}}, comnum}
                - {{RRF_SEL{1'b0}}, grantcnt};
    free_miss   = {1'b0, rrf_freenum} + {2'b00, squash};
    used_cnt    = FREE_MAX_W - {1'b0, rrf_freenum};
  end

  assign dp1_addr   = dispatchptr;
  assign dp2_addr   = dispatchptr + PTR_ONE;
  assign recovering = (state == ST_RECOVER);

  // Misprediction wins over grant and commit: the ROB holds comptr that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      dispatchptr <= '0;
      rrf_freenum <= FREE_MAX;
    end else if (prmiss) begin
      state       <= ST_RECOVER;
      dispatchptr <= prmiss_ptr;
      rrf_freenum <= free_miss[RRF_SEL:0];
    end else begin
      state       <= ST_RUN;
      dispatchptr <= dispatchptr + {{(RRF_SEL-2){1'b0}}, grantcnt};
      rrf_freenum <= free_run[RRF_SEL:0];
    end
  end

  a_req2_needs_req1: assert property (@(posedge clk) disable iff (reset) req2 |-> req1);
  a_free_bound:      assert property (@(posedge clk) disable iff (reset) rrf_freenum <= FREE_MAX);
  a_comnum_bound:    assert property (@(posedge clk) disable iff (reset)
                       {{RRF_SEL{1'b0}}, comnum} <= used_cnt);
  a_squash_bound:    assert property (@(posedge clk) disable iff (reset)
                       prmiss |-> ({2'b00, squash} <= used_cnt));
  a_next_free_bound: assert property (@(posedge clk) disable iff (reset)
                       (prmiss ? free_miss : free_run) <= FREE_MAX_W);

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed self-checking bench for rob_alloc_ctrl: fill/drain, wrap,
// misprediction rollback, back-to-back recovery and asynchronous reset.
module tb_rob_alloc_ctrl;

  localparam int RRF_NUM = 64;
  localparam int RRF_SEL = 6;

  logic               clk;
  logic               reset;
  logic               req1;
  logic               req2;
  logic               stall_ext;
  logic [1:0]         comnum;
  logic               prmiss;
  logic [RRF_SEL-1:0] prmiss_ptr;
  logic               dp1;
  logic               dp2;
  logic [RRF_SEL-1:0] dp1_addr;
  logic [RRF_SEL-1:0] dp2_addr;
  logic [RRF_SEL-1:0] dispatchptr;
  logic [RRF_SEL:0]   rrf_freenum;
  logic               allocatable;
  logic               recovering;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rob_alloc_ctrl #(.RRF_NUM(RRF_NUM), .RRF_SEL(RRF_SEL)) dut (
    .clk         (clk),
    .reset       (reset),
    .req1        (req1),
    .req2        (req2),
    .stall_ext   (stall_ext),
    .comnum      (comnum),
    .prmiss      (prmiss),
    .prmiss_ptr  (prmiss_ptr),
    .dp1         (dp1),
    .dp2         (dp2),
    .dp1_addr    (dp1_addr),
    .dp2_addr    (dp2_addr),
    .dispatchptr (dispatchptr),
    .rrf_freenum (rrf_freenum),
    .allocatable (allocatable),
    .recovering  (recovering)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int observed, input int expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic check_regs(input string tag, input int ptr, input int free, input int rec);
    check_output({tag, ".dispatchptr"}, int'(dispatchptr), ptr);
    check_output({tag, ".rrf_freenum"}, int'(rrf_freenum), free);
    check_output({tag, ".recovering"},  int'(recovering),  rec);
  endtask

  task automatic check_grant(input string tag, input int g1, input int g2, input int alloc);
    check_output({tag, ".dp1"},         int'(dp1),         g1);
    check_output({tag, ".dp2"},         int'(dp2),         g2);
    check_output({tag, ".allocatable"}, int'(allocatable), alloc);
  endtask

  // Inputs change just after a rising edge and settle before combinational checks.
  task automatic apply_stimulus(input logic r1, input logic r2, input logic st,
                                input logic [1:0] cn, input logic pm,
                                input logic [RRF_SEL-1:0] pp);
    req1       = r1;
    req2       = r2;
    stall_ext  = st;
    comnum     = cn;
    prmiss     = pm;
    prmiss_ptr = pp;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req1 = 1'b0; req2 = 1'b0; stall_ext = 1'b0; comnum = 2'd0;
    prmiss = 1'b0; prmiss_ptr = '0;
    #2;
    check_regs("reset", 0, 64, 0);
    check_grant("reset", 0, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    step();

    apply_stimulus(1, 1, 1, 0, 0, 0);
    check_grant("stall", 0, 0, 1);
    step();
    check_regs("stall", 0, 64, 0);

    // Fill the whole buffer two entries at a time.
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1, 1, 0, 0, 0, 0);
      check_grant($sformatf("fill%0d", i), 1, 1, 1);
      check_output($sformatf("fill%0d.dp1_addr", i), int'(dp1_addr), 2 * i);
      check_output($sformatf("fill%0d.dp2_addr", i), int'(dp2_addr), 2 * i + 1);
      step();
      check_regs($sformatf("fill%0d", i), (2 * i + 2) % 64, 64 - 2 * i - 2, 0);
    end
    apply_stimulus(1, 1, 0, 0, 0, 0);
    check_grant("full_pair", 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_grant("full_single", 0, 0, 0);
    step();
    check_regs("full_hold", 0, 0, 0);

    apply_stimulus(1, 1, 0, 1, 0, 0);
    check_grant("full_commit", 0, 0, 0);
    step();
    check_regs("after_commit1", 0, 1, 0);
    apply_stimulus(1, 1, 0, 0, 0, 0);
    check_grant("one_free_pair", 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_grant("one_free_single", 1, 0, 1);
    check_output("one_free_single.dp1_addr", int'(dp1_addr), 0);
    step();
    check_regs("one_free_single", 1, 0, 0);

    // Roll back to 62 (squash 3), then commit up to 10 free entries.
    apply_stimulus(0, 0, 0, 0, 1, 6'd62);
    step();
    check_regs("miss62", 62, 3, 1);
    apply_stimulus(1, 0, 0, 2, 0, 0);
    check_grant("miss62_recover", 0, 0, 1);
    step();
    check_regs("miss62_recover", 62, 5, 0);
    apply_stimulus(0, 0, 0, 2, 0, 0);
    step();
    step();
    apply_stimulus(0, 0, 0, 1, 0, 0);
    step();
    check_regs("setup62", 62, 10, 0);

    apply_stimulus(1, 1, 0, 0, 0, 0);
    check_grant("wrap62", 1, 1, 1);
    check_output("wrap62.dp1_addr", int'(dp1_addr), 62);
    check_output("wrap62.dp2_addr", int'(dp2_addr), 63);
    step();
    check_regs("wrap62", 0, 8, 0);
    apply_stimulus(1, 1, 0, 0, 0, 0);
    check_grant("wrap0", 1, 1, 1);
    check_output("wrap0.dp1_addr", int'(dp1_addr), 0);
    check_output("wrap0.dp2_addr", int'(dp2_addr), 1);
    step();
    check_regs("wrap0", 2, 6, 0);

    // Grant and commit two per cycle: count holds while the pointer moves.
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1, 1, 0, 2, 0, 0);
      step();
    end
    check_regs("net_zero", 20, 6, 0);
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(0, 0, 0, 2, 0, 0);
      step();
    end
    check_regs("setup20", 20, 40, 0);

    apply_stimulus(1, 0, 0, 2, 1, 6'd14);
    check_grant("miss14", 0, 0, 1);
    step();
    check_regs("miss14", 14, 46, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_grant("miss14_recover", 0, 0, 1);
    step();
    check_regs("miss14_run", 14, 46, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_grant("resume14", 1, 0, 1);
    check_output("resume14.dp1_addr", int'(dp1_addr), 14);
    step();
    check_regs("resume14", 15, 45, 0);

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1, 1, 0, 0, 0, 0);
      step();
    end
    apply_stimulus(1, 0, 0, 0, 0, 0);
    step();
    check_regs("setup30", 30, 30, 0);

    apply_stimulus(0, 0, 0, 0, 1, 6'd25);
    step();
    check_regs("b2b_first", 25, 35, 1);
    apply_stimulus(1, 0, 0, 0, 1, 6'd22);
    check_grant("b2b_second", 0, 0, 1);
    step();
    check_regs("b2b_second", 22, 38, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step();
    check_regs("b2b_exit", 22, 38, 0);

    // Roll back across the wrap to 63 (squash 23), then grant 63 and 0.
    apply_stimulus(0, 0, 0, 0, 1, 6'd63);
    step();
    check_regs("miss63", 63, 61, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step();
    apply_stimulus(1, 1, 0, 0, 0, 0);
    check_grant("wrap63", 1, 1, 1);
    check_output("wrap63.dp1_addr", int'(dp1_addr), 63);
    check_output("wrap63.dp2_addr", int'(dp2_addr), 0);
    step();
    check_regs("wrap63", 1, 59, 0);

    for (int i = 0; i < 27; i++) begin
      apply_stimulus(1, 1, 0, 0, 0, 0);
      step();
    end
    check_regs("setup5", 55, 5, 0);
    apply_stimulus(0, 0, 0, 0, 1, 6'd55);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_regs("squash_zero", 55, 5, 1);
    reset = 1'b1;
    #1;
    check_regs("async_reset", 0, 64, 0);
    check_grant("async_reset", 0, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
Allocation controller for the reorder buffer / rename register file (RRF). Grants up to two RRF entries per cycle to the dispatch stage and owns the dispatch pointer and free-entry count that the reorder buffer consumes. Returns entries on commit and rolls the pointer back on branch misprediction. Sits between decode/dispatch and the reorder buffer.

Parameters:
RRF_NUM, 64, number of RRF/ROB entries; power of two, at least 4
RRF_SEL, 6, log2(RRF_NUM); entry index width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous reset, active-high
req1  in  1  dispatch slot 1 holds a valid instruction
req2  in  1  dispatch slot 2 holds a valid instruction; legal only with req1
stall_ext  in  1  downstream stall (reservation stations full)
comnum  in  2  entries committed this cycle, 0..2
prmiss  in  1  branch misprediction, single-cycle pulse
prmiss_ptr  in  RRF_SEL  first entry squashed by the misprediction
dp1  out  1  slot 1 granted (combinational)
dp2  out  1  slot 2 granted (combinational)
dp1_addr  out  RRF_SEL  entry for slot 1; equals dispatchptr
dp2_addr  out  RRF_SEL  entry for slot 2; equals dispatchptr+1 mod RRF_NUM
dispatchptr  out  RRF_SEL  next entry to allocate (registered)
rrf_freenum  out  RRF_SEL+1  free entry count, 0..RRF_NUM (registered)
allocatable  out  1  free count covers the current request (combinational)
recovering  out  1  FSM is in RECOVER (registered)

Behaviour:
- Reset values: dispatchptr=0, rrf_freenum=RRF_NUM, state=RUN, recovering=0. With no requests, dp1=dp2=0 and allocatable=1.
- reqcnt = req1 + (req1 & req2). A request with req2=1 and req1=0 is treated as reqcnt=0. An assertion flags it.
- allocatable = (rrf_freenum >= reqcnt). Compare against the current registered count. Entries freed by comnum this cycle are not visible until the next cycle.
- Grants are all-or-nothing. go = (state==RUN) & ~prmiss & ~stall_ext & allocatable.
  - dp1 = go & req1.
  - dp2 = go & req1 & req2.
  - Slot 1 is never granted without slot 2 when both are requested.
- grantcnt = dp1 + dp2.
- FSM states:
  - RUN: normal operation. prmiss moves to RECOVER.
  - RECOVER: lasts exactly one cycle, then RUN. Grants are blocked and comnum is still accepted. A prmiss arriving during RECOVER re-enters RECOVER with the new rollback applied.
- Normal update (no prmiss):
  - dispatchptr <= dispatchptr + grantcnt, mod RRF_NUM, natural wrap.
  - rrf_freenum <= rrf_freenum + comnum - grantcnt, computed at RRF_SEL+2 bits.
- Misprediction (prmiss=1) takes priority over grant and commit in that cycle:
  - squash = (dispatchptr - prmiss_ptr) mod RRF_NUM.
  - dispatchptr <= prmiss_ptr.
  - rrf_freenum <= rrf_freenum + squash.
  - comnum is ignored, because the reorder buffer does not advance comptr under prmiss.
  - squash=0 means nothing is squashed. This covers prmiss_ptr==dispatchptr, including a full buffer.
- Boundaries:
  - rrf_freenum==0: allocatable=0 for any request, so the buffer stays full.
  - rrf_freenum==1 with a two-slot request: both slots are denied.
  - Pointer wrap: from 62, a two-slot grant gives addresses 62 and 63; from 63 it gives 63 and 0.
  - Commit and grant in the same cycle net correctly: count 0, comnum=2, reqcnt=2 gives no grant this cycle and count 2 next cycle.
- Reset asserted mid-operation returns every register to its reset value immediately, regardless of state.
- Assertions:
  - rrf_freenum never exceeds RRF_NUM.
  - comnum never exceeds RRF_NUM - rrf_freenum.
  - squash never exceeds RRF_NUM - rrf_freenum.

Test Plan:
- Reset, then 32 cycles of req1=req2=1 with comnum=0 -> dispatchptr advances 0,2,4,...,0. rrf_freenum reaches 0 after 32 grants. Cycle 33 shows dp1=dp2=0, allocatable=0.
- Full buffer, comnum=1 for one cycle with req1=req2=1 -> next cycle rrf_freenum=1 and no grants. Then req2=0 -> dp1=1, dp1_addr=0, rrf_freenum=0.
- dispatchptr=62, rrf_freenum=10, two-slot request -> dp1_addr=62, dp2_addr=63. Next cycle dispatchptr=0, rrf_freenum=8; a further two-slot grant gives addresses 0 and 1.
- dispatchptr=20, rrf_freenum=40, prmiss=1 with prmiss_ptr=14, comnum=2, req1=1 -> no grant. Next cycle dispatchptr=14, rrf_freenum=46, recovering=1 and grants blocked. The cycle after: RUN, and grants resume at address 14.
- Back-to-back prmiss: cycle 1 ptr 30->25, cycle 2 (RECOVER) prmiss_ptr=22 -> dispatchptr=22, rrf_freenum up by 8 total. RECOVER is held one more cycle.
- Assert reset during RECOVER with rrf_freenum=5 -> dispatchptr=0, rrf_freenum=64 and recovering=0 without waiting for a clock edge.
